control_sequencer: RTL and testbench

//   Hardwired control unit that sits directly upstream of the datapath. It drives

---
 rtl/control_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch steps T0-T2, then opcode-specific execute steps.
// Drives every datapath strobe from the current step; Illegal latches undefined opcodes.
module control_sequencer #(
    parameter int unsigned MEM_WAIT = 0,
    parameter logic [4:0]  OPC_ADDI = 5'b01100,
    parameter logic [4:0]  OPC_BR   = 5'b10010,
    parameter logic [4:0]  OPC_JR   = 5'b10011,
    parameter logic [4:0]  OPC_NOP  = 5'b11010,
    parameter logic [4:0]  OPC_HALT = 5'b11011
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Read,
    output logic        MDRin,
    output logic        PCin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Gra,
    output logic        Grb,
    output logic        Rin,
    output logic        Rout,
    output logic        CONin,
    output logic        Yin,
    output logic        Cout,
    output logic        ZLOout,
    output logic        ADD,
    output logic        Running,
    output logic        Illegal,
    output logic [3:0]  Step
);

    typedef enum logic [3:0] {
        S_T0      = 4'd0,
        S_T1      = 4'd1,
        S_T2      = 4'd2,
        S_T3      = 4'd3,
        S_ADDI_T4 = 4'd4,
        S_ADDI_T5 = 4'd5,
        S_BR_T4   = 4'd6,
        S_BR_T5   = 4'd7,
        S_BR_T6   = 4'd8,
        S_HALT    = 4'd14,
        S_RST     = 4'd15
    } state_t;

    localparam logic [3:0] LP_WAIT = 4'(MEM_WAIT);

    state_t     r_state;
    logic [3:0] r_wait_cnt;
    logic       r_illegal;

    logic [4:0] w_opcode;
    logic       w_last_wait;
    state_t     w_next_instr;
    logic       w_unused_ir;

    assign w_opcode     = IR[31:27];
    assign w_last_wait  = (r_wait_cnt == LP_WAIT);
    assign w_next_instr = Stop ? S_HALT : S_T0;
    assign w_unused_ir  = ^IR[26:0];
    assign Illegal      = r_illegal;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state    <= S_RST;
            r_wait_cnt <= 4'd0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                S_RST: r_state <= S_T0;
                S_T0:  r_state <= S_T1;
                S_T1: begin
                    if (w_last_wait) begin
                        r_wait_cnt <= 4'd0;
                        r_state    <= S_T2;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                S_T2: r_state <= S_T3;
                S_T3: begin
                    if (w_opcode == OPC_ADDI) begin
                        r_state <= S_ADDI_T4;
                    end else if (w_opcode == OPC_BR) begin
                        r_state <= S_BR_T4;
                    end else if ((w_opcode == OPC_JR) || (w_opcode == OPC_NOP)) begin
                        r_state <= w_next_instr;
                    end else if (w_opcode == OPC_HALT) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end
                end
                S_ADDI_T4: r_state <= S_ADDI_T5;
                S_ADDI_T5: r_state <= w_next_instr;
                S_BR_T4:   r_state <= S_BR_T5;
                S_BR_T5:   r_state <= S_BR_T6;
                S_BR_T6:   r_state <= w_next_instr;
                S_HALT:    r_state <= S_HALT;
                default:   r_state <= S_RST;
            endcase
        end
    end

    // Strobes decode straight from the state flops so an asynchronous reset silences them at once.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        PCout   = 1'b0;
        MARin   = 1'b0;
        IncPC   = 1'b0;
        Zin     = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        PCin    = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        CONin   = 1'b0;
        Yin     = 1'b0;
        Cout    = 1'b0;
        ZLOout  = 1'b0;
        ADD     = 1'b0;
        Running = (r_state != S_RST) && (r_state != S_HALT);
        Step    = 4'd15;
        case (r_state)
            S_T0: begin
                Step  = 4'd0;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Step   = 4'd1;
                ZLOout = 1'b1;
                Read   = 1'b1;
                MDRin  = 1'b1;
                PCin   = w_last_wait;
            end
            S_T2: begin
                Step   = 4'd2;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Step = 4'd3;
                if (w_opcode == OPC_ADDI) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (w_opcode == OPC_BR) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    CONin = 1'b1;
                end else if (w_opcode == OPC_JR) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    PCin = 1'b1;
                end
            end
            S_ADDI_T4, S_BR_T5: begin
                Step = (r_state == S_BR_T5) ? 4'd5 : 4'd4;
                Cout = 1'b1;
                ADD  = 1'b1;
                Zin  = 1'b1;
            end
            S_ADDI_T5: begin
                Step   = 4'd5;
                ZLOout = 1'b1;
                Gra    = 1'b1;
                Rin    = 1'b1;
            end
            S_BR_T4: begin
                Step  = 4'd4;
                PCout = 1'b1;
                Yin   = 1'b1;
            end
            S_BR_T6: begin
                Step   = 4'd6;
                ZLOout = 1'b1;
                PCin   = CON;
            end
            S_HALT:  Step = 4'd14;
            default: Step = 4'd15;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues expected step snapshots,
// a monitor pops one per sample point and compares strobes, Running, Illegal and Step.
module tb_control_sequencer;

    localparam logic [17:0] M_PCOUT  = 18'h1 << 17;
    localparam logic [17:0] M_MARIN  = 18'h1 << 16;
    localparam logic [17:0] M_INCPC  = 18'h1 << 15;
    localparam logic [17:0] M_ZIN    = 18'h1 << 14;
    localparam logic [17:0] M_READ   = 18'h1 << 13;
    localparam logic [17:0] M_MDRIN  = 18'h1 << 12;
    localparam logic [17:0] M_PCIN   = 18'h1 << 11;
    localparam logic [17:0] M_MDROUT = 18'h1 << 10;
    localparam logic [17:0] M_IRIN   = 18'h1 << 9;
    localparam logic [17:0] M_GRA    = 18'h1 << 8;
    localparam logic [17:0] M_GRB    = 18'h1 << 7;
    localparam logic [17:0] M_RIN    = 18'h1 << 6;
    localparam logic [17:0] M_ROUT   = 18'h1 << 5;
    localparam logic [17:0] M_CONIN  = 18'h1 << 4;
    localparam logic [17:0] M_YIN    = 18'h1 << 3;
    localparam logic [17:0] M_COUT   = 18'h1 << 2;
    localparam logic [17:0] M_ZLOOUT = 18'h1 << 1;
    localparam logic [17:0] M_ADD    = 18'h1;

    localparam logic [17:0] X_T0  = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [17:0] X_T1W = M_ZLOOUT | M_READ | M_MDRIN;
    localparam logic [17:0] X_T1  = X_T1W | M_PCIN;
    localparam logic [17:0] X_T2  = M_MDROUT | M_IRIN;
    localparam logic [17:0] X_A3  = M_GRB | M_ROUT | M_YIN;
    localparam logic [17:0] X_A4  = M_COUT | M_ADD | M_ZIN;
    localparam logic [17:0] X_A5  = M_ZLOOUT | M_GRA | M_RIN;
    localparam logic [17:0] X_B3  = M_GRA | M_ROUT | M_CONIN;
    localparam logic [17:0] X_B4  = M_PCOUT | M_YIN;
    localparam logic [17:0] X_B5  = M_COUT | M_ADD | M_ZIN;
    localparam logic [17:0] X_B6  = M_ZLOOUT;
    localparam logic [17:0] X_J3  = M_GRA | M_ROUT | M_PCIN;

    localparam logic [31:0] I_ADDI = {5'b01100, 4'd3, 4'd2, 19'h7FFFB};
    localparam logic [31:0] I_BR   = {5'b10010, 4'd5, 4'd0, 19'h00001};
    localparam logic [31:0] I_JR   = {5'b10011, 4'd7, 23'd0};
    localparam logic [31:0] I_NOP  = {5'b11010, 27'd0};
    localparam logic [31:0] I_HALT = {5'b11011, 27'd0};
    localparam logic [31:0] I_ILL  = {5'b11111, 27'd0};

    typedef struct packed {
        logic [17:0] strb;
        logic        run;
        logic        ill;
        logic [3:0]  step;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ir = I_ADDI;
    logic        con = 1'b0;
    logic        stop = 1'b0;
    logic        kick = 1'b0;

    wire [17:0] s0, s3;
    wire        run0, run3, ill0, ill3;
    wire [3:0]  step0, step3;

    exp_t  q0[$], q3[$];
    string n0[$], n3[$];
    int    sel = 0;
    logic  ill_exp = 1'b0;
    int    n_checks = 0;
    int    n_errors = 0;

    always #5 clk = ~clk;

    control_sequencer #(.MEM_WAIT(0)) dut0 (
        .Clock(clk), .Resetn(rst_n), .IR(ir), .CON(con), .Stop(stop),
        .PCout(s0[17]), .MARin(s0[16]), .IncPC(s0[15]), .Zin(s0[14]),
        .Read(s0[13]), .MDRin(s0[12]), .PCin(s0[11]), .MDRout(s0[10]),
        .IRin(s0[9]), .Gra(s0[8]), .Grb(s0[7]), .Rin(s0[6]), .Rout(s0[5]),
        .CONin(s0[4]), .Yin(s0[3]), .Cout(s0[2]), .ZLOout(s0[1]), .ADD(s0[0]),
        .Running(run0), .Illegal(ill0), .Step(step0)
    );

    control_sequencer #(.MEM_WAIT(3)) dut3 (
        .Clock(clk), .Resetn(rst_n), .IR(ir), .CON(con), .Stop(stop),
        .PCout(s3[17]), .MARin(s3[16]), .IncPC(s3[15]), .Zin(s3[14]),
        .Read(s3[13]), .MDRin(s3[12]), .PCin(s3[11]), .MDRout(s3[10]),
        .IRin(s3[9]), .Gra(s3[8]), .Grb(s3[7]), .Rin(s3[6]), .Rout(s3[5]),
        .CONin(s3[4]), .Yin(s3[3]), .Cout(s3[2]), .ZLOout(s3[1]), .ADD(s3[0]),
        .Running(run3), .Illegal(ill3), .Step(step3)
    );

    task automatic check(input string name, input exp_t got, input exp_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got strb=%h run=%b ill=%b step=%0d, expected strb=%h run=%b ill=%b step=%0d",
                     name, got.strb, got.run, got.ill, got.step, exp.strb, exp.run, exp.ill, exp.step);
        end
    endtask

    // Monitor: samples on the falling edge, or on a kick for mid-cycle asynchronous events.
    initial begin
        forever begin
            @(negedge clk or posedge kick);
            if (q0.size() > 0) check(n0.pop_front(), {s0, run0, ill0, step0}, q0.pop_front());
            if (q3.size() > 0) check(n3.pop_front(), {s3, run3, ill3, step3}, q3.pop_front());
        end
    end

    task automatic push(input logic [17:0] s, input logic [3:0] st, input logic run,
                        input logic ill, input string nm);
        exp_t e;
        e = '{strb: s, run: run, ill: ill, step: st};
        if (sel == 0) begin
            q0.push_back(e);
            n0.push_back(nm);
        end else begin
            q3.push_back(e);
            n3.push_back(nm);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic e_run(input logic [17:0] s, input logic [3:0] st, input string nm);
        push(s, st, 1'b1, ill_exp, nm);
    endtask

    task automatic do_reset();
        tick();
        rst_n   = 1'b0;
        ill_exp = 1'b0;
        push('0, 4'd15, 1'b0, 1'b0, "RST");
        tick();
        rst_n = 1'b1;
        push('0, 4'd15, 1'b0, 1'b0, "RST_release");
    endtask

    task automatic fetch(input int mw, input logic [31:0] instr);
        tick();
        ir = instr;
        e_run(X_T0, 4'd0, "T0");
        for (int i = 0; i < mw; i++) begin
            tick();
            e_run(X_T1W, 4'd1, "T1_wait");
        end
        tick();
        e_run(X_T1, 4'd1, "T1_last");
        tick();
        e_run(X_T2, 4'd2, "T2");
    endtask

    task automatic halt_cycle(input string nm);
        tick();
        push('0, 4'd14, 1'b0, ill_exp, nm);
    endtask

    task automatic run_br(input logic con_val, input string nm);
        fetch(0, I_BR);
        tick();
        e_run(X_B3, 4'd3, "BR_T3");
        tick();
        con = con_val;
        e_run(X_B4, 4'd4, "BR_T4");
        tick();
        e_run(X_B5, 4'd5, "BR_T5");
        tick();
        e_run(con_val ? (X_B6 | M_PCIN) : X_B6, 4'd6, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        // addi from reset: 15,0,1,2,3,4,5 then the next fetch starts at T0
        do_reset();
        fetch(0, I_ADDI);
        tick(); e_run(X_A3, 4'd3, "ADDI_T3");
        tick(); e_run(X_A4, 4'd4, "ADDI_T4");
        tick(); e_run(X_A5, 4'd5, "ADDI_T5");

        // br taken, br not taken, each followed directly by the next T0
        run_br(1'b1, "BR_T6_con1");
        run_br(1'b0, "BR_T6_con0");
        fetch(0, I_NOP);
        tick(); e_run('0, 4'd3, "NOP_T3");

        // jr with Stop raised in T1: jr finishes, then HALT
        tick(); ir = I_JR; e_run(X_T0, 4'd0, "JR_T0");
        tick(); stop = 1'b1; e_run(X_T1, 4'd1, "JR_T1_stop");
        tick(); e_run(X_T2, 4'd2, "JR_T2");
        tick(); e_run(X_J3, 4'd3, "JR_T3");
        halt_cycle("JR_HALT");
        stop = 1'b0;
        halt_cycle("JR_HALT_hold");

        // addi with Stop raised in T4: T5 still appears, then HALT sticks
        do_reset();
        fetch(0, I_ADDI);
        tick(); e_run(X_A3, 4'd3, "ADDI_T3");
        tick(); stop = 1'b1; e_run(X_A4, 4'd4, "ADDI_T4_stop");
        tick(); e_run(X_A5, 4'd5, "ADDI_T5_stop");
        halt_cycle("ADDI_HALT");
        stop = 1'b0;
        halt_cycle("ADDI_HALT_hold1");
        halt_cycle("ADDI_HALT_hold2");

        // halt opcode
        do_reset();
        fetch(0, I_HALT);
        tick(); e_run('0, 4'd3, "HALTOP_T3");
        halt_cycle("HALTOP_HALT");
        halt_cycle("HALTOP_HALT_hold");

        // illegal opcode: sticky flag for 20 cycles, cleared by reset
        do_reset();
        fetch(0, I_ILL);
        tick(); e_run('0, 4'd3, "ILL_T3");
        ill_exp = 1'b1;
        for (int i = 0; i < 20; i++) halt_cycle("ILL_HALT");
        do_reset();
        fetch(0, I_NOP);
        tick(); e_run('0, 4'd3, "POST_ILL_NOP_T3");

        // MEM_WAIT=3 instance: four Read/MDRin cycles, PCin on the fourth, IRin on the fifth
        sel = 3;
        do_reset();
        fetch(3, I_NOP);
        tick(); e_run('0, 4'd3, "MW3_NOP_T3");
        tick(); e_run(X_T0, 4'd0, "MW3_T0_next");
        sel = 0;

        // asynchronous reset in the middle of br T4
        do_reset();
        fetch(0, I_BR);
        tick(); e_run(X_B3, 4'd3, "BR_T3");
        tick(); con = 1'b1; e_run(X_B4, 4'd4, "BR_T4_pre_reset");
        #6;
        rst_n = 1'b0;
        #1;
        push('0, 4'd15, 1'b0, 1'b0, "ASYNC_RST_mid_T4");
        kick = 1'b1;
        #1;
        kick = 1'b0;
        tick(); push('0, 4'd15, 1'b0, 1'b0, "ASYNC_RST_held");
        tick(); rst_n = 1'b1; push('0, 4'd15, 1'b0, 1'b0, "ASYNC_RST_release");
        fetch(0, I_NOP);
        tick(); e_run('0, 4'd3, "POST_ASYNC_NOP_T3");

        tick();
        tick();
        n_checks++;
        if ((q0.size() != 0) || (q3.size() != 0)) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0/0", q0.size(), q3.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
